// File: rtl/vec_serializer.sv
// Packed-vector to element-stream serializer: accepts N elements of W bits at once
// and emits them one per output handshake, element 0 first, with index and last flag.
module vec_serializer #(
    parameter int N  = 4,
    parameter int W  = 1,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           io_in_valid,
    output logic           io_in_ready,
    input  logic [N*W-1:0] io_in_bits,
    output logic           io_out_valid,
    input  logic           io_out_ready,
    output logic [W-1:0]   io_out_bits,
    output logic [IW-1:0]  io_out_idx,
    output logic           io_out_last
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    state_t           state_p0, state_nxt;
    logic [IW-1:0]    idx_p0, idx_nxt;
    logic [N*W-1:0]   hold_p0, hold_nxt;
    logic             is_last;
    logic             in_fire;
    logic             out_fire;

    // Mux-tree element select; the loop keeps the index within the legal range
    // even when N is not a power of two.
    function automatic logic [W-1:0] pick_elem(input logic [N*W-1:0] vec,
                                               input logic [IW-1:0]  sel);
        logic [W-1:0] e;
        e = '0;
        for (int k = 0; k < N; k++) begin
            if (sel == IW'(k)) begin
                e = vec[k*W +: W];
            end
        end
        return e;
    endfunction

    always_comb begin
        is_last      = (idx_p0 == LAST_IDX);
        io_out_valid = (state_p0 == SEND);
        io_out_bits  = pick_elem(hold_p0, idx_p0);
        io_out_idx   = idx_p0;
        io_out_last  = is_last;
        // Ready opens in the final-element cycle so a new vector follows with no bubble.
        io_in_ready  = (state_p0 == IDLE) ||
                       ((state_p0 == SEND) && is_last && io_out_ready);
        in_fire      = io_in_valid && io_in_ready;
        out_fire     = io_out_valid && io_out_ready;
    end

    always_comb begin
        state_nxt = state_p0;
        idx_nxt   = idx_p0;
        hold_nxt  = hold_p0;
        if (in_fire) begin
            state_nxt = SEND;
            idx_nxt   = '0;
            hold_nxt  = io_in_bits;
        end else if (out_fire) begin
            if (is_last) begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end else begin
                idx_nxt   = idx_p0 + IW'(1);
            end
        end
    end

    // Stage p0: FSM state, element index and holding register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_p0 <= IDLE;
            idx_p0   <= '0;
            hold_p0  <= '0;
        end else begin
            state_p0 <= state_nxt;
            idx_p0   <= idx_nxt;
            hold_p0  <= hold_nxt;
        end
    end

endmodule

// File: tb/tb_vec_serializer.sv
// Directed bench for vec_serializer: N=4/W=1 instance for the main scenarios and
// an N=1/W=8 instance for the single-element case.
module tb_vec_serializer;

    logic       clk;
    logic       reset;

    logic       a_in_valid;
    logic       a_in_ready;
    logic [3:0] a_in_bits;
    logic       a_out_valid;
    logic       a_out_ready;
    logic [0:0] a_out_bits;
    logic [1:0] a_out_idx;
    logic       a_out_last;

    logic       b_in_valid;
    logic       b_in_ready;
    logic [7:0] b_in_bits;
    logic       b_out_valid;
    logic       b_out_ready;
    logic [7:0] b_out_bits;
    logic [0:0] b_out_idx;
    logic       b_out_last;

    int total;
    int bad;

    vec_serializer #(.N(4), .W(1)) dut_a (
        .clk          (clk),
        .reset        (reset),
        .io_in_valid  (a_in_valid),
        .io_in_ready  (a_in_ready),
        .io_in_bits   (a_in_bits),
        .io_out_valid (a_out_valid),
        .io_out_ready (a_out_ready),
        .io_out_bits  (a_out_bits),
        .io_out_idx   (a_out_idx),
        .io_out_last  (a_out_last)
    );

    vec_serializer #(.N(1), .W(8)) dut_b (
        .clk          (clk),
        .reset        (reset),
        .io_in_valid  (b_in_valid),
        .io_in_ready  (b_in_ready),
        .io_in_bits   (b_in_bits),
        .io_out_valid (b_out_valid),
        .io_out_ready (b_out_ready),
        .io_out_bits  (b_out_bits),
        .io_out_idx   (b_out_idx),
        .io_out_last  (b_out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_a(input string tag, input logic v, input logic b,
                            input logic [1:0] i, input logic l);
        check_eq({tag, ".valid"}, 32'(a_out_valid), 32'(v));
        check_eq({tag, ".bits"},  32'(a_out_bits),  32'(b));
        check_eq({tag, ".idx"},   32'(a_out_idx),   32'(i));
        check_eq({tag, ".last"},  32'(a_out_last),  32'(l));
    endtask

    // Offer one vector on dut_a from IDLE; returns with dut_a at idx 0.
    task automatic load_a(input logic [3:0] vec);
        a_in_valid = 1'b1;
        a_in_bits  = vec;
        #1;
        check_eq("load.in_ready", 32'(a_in_ready), 32'd1);
        tick();
        a_in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] vec;
        logic [7:0] stream;
        total       = 0;
        bad         = 0;
        reset       = 1'b0;
        a_in_valid  = 1'b0;
        a_in_bits   = '0;
        a_out_ready = 1'b0;
        b_in_valid  = 1'b0;
        b_in_bits   = '0;
        b_out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;

        // Reset state
        expect_a("rst", 1'b0, 1'b0, 2'd0, 1'b0);
        check_eq("rst.in_ready", 32'(a_in_ready), 32'd1);
        check_eq("rst_b.valid", 32'(b_out_valid), 32'd0);
        check_eq("rst_b.bits", 32'(b_out_bits), 32'd0);
        check_eq("rst_b.in_ready", 32'(b_in_ready), 32'd1);

        // Basic 4'b1011 -> 1,1,0,1
        vec = 4'b1011;
        a_out_ready = 1'b1;
        load_a(vec);
        for (int k = 0; k < 4; k++) begin
            #1;
            expect_a($sformatf("basic%0d", k), 1'b1, vec[k], 2'(k), k == 3);
            check_eq($sformatf("basic%0d.in_ready", k), 32'(a_in_ready), 32'(k == 3));
            tick();
        end
        #1;
        check_eq("basic.idle_valid", 32'(a_out_valid), 32'd0);
        check_eq("basic.idle_ready", 32'(a_in_ready), 32'd1);

        // Backpressure at idx 1 for 3 cycles
        load_a(4'b1011);
        tick();
        a_out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            expect_a($sformatf("bp_hold%0d", k), 1'b1, 1'b1, 2'd1, 1'b0);
            check_eq("bp.in_ready", 32'(a_in_ready), 32'd0);
            tick();
        end
        a_out_ready = 1'b1;
        #1;
        expect_a("bp_idx1", 1'b1, 1'b1, 2'd1, 1'b0);
        tick();
        expect_a("bp_idx2", 1'b1, 1'b0, 2'd2, 1'b0);
        tick();
        expect_a("bp_idx3", 1'b1, 1'b1, 2'd3, 1'b1);
        tick();
        check_eq("bp.idle_valid", 32'(a_out_valid), 32'd0);

        // Back-to-back 4'b0110 then 4'b1001 -> 0,1,1,0,1,0,0,1
        stream = 8'b1001_0110;
        a_in_valid = 1'b1;
        a_in_bits  = 4'b0110;
        #1;
        check_eq("b2b.first_ready", 32'(a_in_ready), 32'd1);
        tick();
        a_in_bits = 4'b1001;
        for (int k = 0; k < 8; k++) begin
            #1;
            expect_a($sformatf("b2b%0d", k), 1'b1, stream[k], 2'(k % 4), (k % 4) == 3);
            if (k == 3) check_eq("b2b.handoff_ready", 32'(a_in_ready), 32'd1);
            tick();
            if (k == 3) a_in_valid = 1'b0;
        end
        check_eq("b2b.idle_valid", 32'(a_out_valid), 32'd0);

        // Foreign 4'b1111 offered at idx 1 and 2 must be ignored
        vec = 4'b0100;
        load_a(vec);
        tick();
        a_in_valid = 1'b1;
        a_in_bits  = 4'b1111;
        #1;
        check_eq("ign.in_ready1", 32'(a_in_ready), 32'd0);
        expect_a("ign1", 1'b1, vec[1], 2'd1, 1'b0);
        tick();
        #1;
        check_eq("ign.in_ready2", 32'(a_in_ready), 32'd0);
        expect_a("ign2", 1'b1, vec[2], 2'd2, 1'b0);
        tick();
        a_in_valid = 1'b0;
        #1;
        expect_a("ign3", 1'b1, vec[3], 2'd3, 1'b1);
        tick();
        check_eq("ign.idle_valid", 32'(a_out_valid), 32'd0);

        // Reset at idx 2, then 4'b0001 -> 1,0,0,0
        load_a(4'b1011);
        tick();
        tick();
        #1;
        expect_a("rmid_idx2", 1'b1, 1'b0, 2'd2, 1'b0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        expect_a("rmid_after", 1'b0, 1'b0, 2'd0, 1'b0);
        check_eq("rmid.in_ready", 32'(a_in_ready), 32'd1);
        vec = 4'b0001;
        load_a(vec);
        for (int k = 0; k < 4; k++) begin
            #1;
            expect_a($sformatf("rmid_vec%0d", k), 1'b1, vec[k], 2'(k), k == 3);
            tick();
        end
        check_eq("rmid.idle_valid", 32'(a_out_valid), 32'd0);

        // N=1, W=8: A5 then 3C back-to-back
        b_out_ready = 1'b1;
        b_in_valid  = 1'b1;
        b_in_bits   = 8'hA5;
        #1;
        check_eq("n1.ready0", 32'(b_in_ready), 32'd1);
        tick();
        b_in_bits = 8'h3C;
        #1;
        check_eq("n1.valid_a5", 32'(b_out_valid), 32'd1);
        check_eq("n1.bits_a5", 32'(b_out_bits), 32'hA5);
        check_eq("n1.last_a5", 32'(b_out_last), 32'd1);
        check_eq("n1.idx_a5", 32'(b_out_idx), 32'd0);
        check_eq("n1.ready_a5", 32'(b_in_ready), 32'd1);
        tick();
        b_in_valid = 1'b0;
        #1;
        check_eq("n1.valid_3c", 32'(b_out_valid), 32'd1);
        check_eq("n1.bits_3c", 32'(b_out_bits), 32'h3C);
        check_eq("n1.last_3c", 32'(b_out_last), 32'd1);
        tick();
        check_eq("n1.idle_valid", 32'(b_out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vec_serializer.md
VEC_SERIALIZER -- requirements
Module: vec_serializer

Interface
REQ-001 Parameter N: default 4; number of vector elements, legal range 1..16.
REQ-002 Parameter W: default 1; width of each element in bits, minimum 1.
REQ-003 Parameter IW: default max(1, clog2(N)); width of the element index.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; sampled on clk rising edge, state cleared when 0.
REQ-006 io_in_valid  input  1  producer offers a packed vector.
REQ-007 io_in_ready  output  1  block accepts a packed vector this cycle.
REQ-008 io_in_bits  input  N*W  packed vector; element k occupies bits [k*W+W-1 : k*W], so element 0 is at the LSBs.
REQ-009 io_out_valid  output  1  io_out_bits holds a valid element.
REQ-010 io_out_ready  input  1  consumer takes the element this cycle.
REQ-011 io_out_bits  output  W  current element.
REQ-012 io_out_idx  output  IW  index of the current element.
REQ-013 io_out_last  output  1  current element is element N-1.

Function
REQ-014 Input handshake: a transfer occurs in any cycle where io_in_valid=1 and io_in_ready=1.
REQ-015 Output handshake: a transfer occurs in any cycle where io_out_valid=1 and io_out_ready=1.
REQ-016 State machine: two states, IDLE and SEND.
REQ-017 IDLE outputs: io_in_ready=1 and io_out_valid=0.
REQ-018 IDLE to SEND: on an input transfer, register io_in_bits into a holding register, set idx=0, and enter SEND on the next cycle.
REQ-019 SEND outputs: io_out_valid=1, io_out_bits = holding element idx, io_out_idx=idx, io_out_last = (idx==N-1).
REQ-020 SEND, output transfer with idx<N-1: idx increments by 1; state stays SEND.
REQ-021 SEND, output transfer with idx==N-1: block drops back, entering IDLE if no new vector is accepted in the same cycle.
REQ-022 Back-to-back vectors: io_in_ready = IDLE OR (SEND AND io_out_last AND io_out_ready); this is a combinational path from io_out_ready.
REQ-023 Back-to-back load: an input transfer in the final-element cycle loads the new vector, sets idx=0 and stays in SEND; no bubble between vectors.
REQ-024 Backpressure: while io_out_valid=1 and io_out_ready=0, io_out_bits, io_out_idx, io_out_last and the holding register are held stable.
REQ-025 Foreign input during SEND: io_in_valid is ignored whenever io_in_ready=0, and the holding register is unchanged.
REQ-026 N=1 case: io_out_last=1 for every element; each vector takes one output transfer.
REQ-027 Throughput: with io_out_ready held at 1 and input continuously valid, the block emits one element per cycle.
REQ-028 Latency: the first element of a vector appears on io_out one cycle after its input transfer.

Reset
REQ-029 While reset=0 at a clk edge, the block clears to: state=IDLE, idx=0, holding register=0.
REQ-030 Output values immediately after reset: io_out_valid=0, io_out_bits=0, io_out_idx=0, io_out_last=0 (N>1), io_in_ready=1.
REQ-031 Reset asserted mid-vector discards the remaining elements; no output transfer occurs in the cycle after reset.
REQ-032 No state is held in an initial or undefined value beyond the first reset cycle.

Verification (N=4, W=1 unless noted)
REQ-033 Basic: io_in_bits=4'b1011 accepted, io_out_ready=1 -> io_out_bits 1,1,0,1 with idx 0..3 on consecutive cycles; io_out_last=1 only at idx 3; then IDLE with io_in_ready=1.
REQ-034 Backpressure: io_out_ready=0 for 3 cycles at idx 1 -> io_out_bits=1, idx=1 held for all 3 cycles, resumes at idx 2 once ready returns.
REQ-035 Back-to-back: 4'b0110 then 4'b1001, both valid, io_out_ready=1 -> output stream 0,1,1,0,1,0,0,1 over 8 consecutive cycles with no bubble.
REQ-036 Ignored input: io_in_valid=1 with 4'b1111 during SEND at idx 1 -> io_in_ready=0 and the current vector's remaining elements are unchanged.
REQ-037 Reset mid-op: reset=0 for one cycle at idx 2 -> next cycle io_out_valid=0, io_in_ready=1; a subsequent vector 4'b0001 emits 1,0,0,0 correctly.
REQ-038 N=1, W=8: vectors 8'hA5 then 8'h3C, io_out_ready=1 -> outputs A5, 3C on consecutive cycles, io_out_last=1 on both.
